// File: rtl/debug_uart_wb_bridge.sv
// ----------------------------------------------------------------------------
// debug_uart_wb_bridge
//
// Device-side responder for the host debug UART link. It receives framed
// command bytes on debug_in, runs Wishbone master writes and reads on the
// management bus, and returns read data serially on debug_out.
//
// Frame: cmd (0x01 write, 0x02 read), N (word count), 4-byte word address
// (MSB first), then N 32-bit words MSB first (writes only). Each read word is
// answered with 4 bytes, MSB first.
//
// Optional feature: define DEBUG_BRIDGE_WB_TIMEOUT_EN to abandon a bus cycle
// after WB_TIMEOUT cycles without ack. The abandoned cycle sets err, and a
// read returns 32'hFFFFFFFF. Without the macro the bridge waits for ack
// indefinitely.
//
// Ports:
//   core_clk, core_rstn   clock, asynchronous active-low reset
//   debug_in              UART RX from the pad (asynchronous)
//   debug_out, debug_oeb  UART TX to the pad (idle high), pad OE (active low)
//   enable                bridge enable; 0 holds the frame FSM in IDLE
//   wb_*                  Wishbone master (sel is always 4'hF)
//   busy                  frame FSM is not IDLE
//   err                   sticky error: framing, byte timeout, bus timeout
// ----------------------------------------------------------------------------
module debug_uart_wb_bridge #(
    parameter int CLKS_PER_BIT = 347,
    parameter int BYTE_TIMEOUT = 65535,
    parameter int WB_TIMEOUT   = 255
) (
    input  logic        core_clk,
    input  logic        core_rstn,
    input  logic        debug_in,
    output logic        debug_out,
    output logic        debug_oeb,
    input  logic        enable,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i,
    output logic        busy,
    output logic        err
);

    localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [7:0] CMD_WR = 8'h01;
    localparam logic [7:0] CMD_RD = 8'h02;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WB_WR, S_WB_RD, S_TX
    } state_t;

    // ------------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------------
    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    rx_state_t        r_rx_state;
    logic [BIT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;   // doubles as the received byte when r_rx_valid
    logic             r_rx_valid;   // one-cycle pulse: byte with a good stop bit
    logic             r_rx_ferr;    // one-cycle pulse: stop bit sampled low

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            // NOTE: debug_in is asynchronous to core_clk; only r_rx_sync (two
            // flops downstream) may feed any decision, never debug_in itself.
            r_rx_meta  <= debug_in;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_cnt <= '0;
                    if (r_rx_prev && !r_rx_sync) r_rx_state <= RX_START;
                end
                RX_START: begin
                    // Line back high at the half-bit point: a glitch, not a start bit.
                    if (r_rx_cnt == BIT_HALF) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + BIT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
                        r_rx_bit   <= r_rx_bit + 3'd1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + BIT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        r_rx_valid <= r_rx_sync;
                        r_rx_ferr  <= !r_rx_sync;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + BIT_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // UART transmitter (8N1, LSB first)
    // ------------------------------------------------------------------------
    logic             r_tx_start;   // request from the frame FSM
    logic [7:0]       r_tx_data;
    logic             r_tx_busy;
    logic             r_tx_out;
    logic [8:0]       r_tx_shift;   // data bits then stop bit
    logic [3:0]       r_tx_bitn;    // bit periods still to send after the current one
    logic [BIT_W-1:0] r_tx_cnt;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_tx_busy  <= 1'b0;
            r_tx_out   <= 1'b1;
            r_tx_shift <= '0;
            r_tx_bitn  <= '0;
            r_tx_cnt   <= '0;
        end else if (!r_tx_busy) begin
            r_tx_out <= 1'b1;
            r_tx_cnt <= '0;
            if (r_tx_start) begin
                r_tx_busy  <= 1'b1;
                r_tx_out   <= 1'b0;
                r_tx_shift <= {1'b1, r_tx_data};
                r_tx_bitn  <= 4'd9;
            end
        end else if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bitn == 4'd0) begin
                r_tx_busy <= 1'b0;
                r_tx_out  <= 1'b1;
            end else begin
                r_tx_out   <= r_tx_shift[0];
                r_tx_shift <= {1'b0, r_tx_shift[8:1]};
                r_tx_bitn  <= r_tx_bitn - 4'd1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + BIT_W'(1);
        end
    end

    // Ready only once an issued start has actually been taken by the transmitter.
    logic w_tx_ready;
    assign w_tx_ready = !r_tx_busy && !r_tx_start;

    // ------------------------------------------------------------------------
    // Bus completion: ack while strobing, or (optionally) a bus timeout
    // ------------------------------------------------------------------------
    logic r_stb;
    logic w_ack, w_wb_tmo, w_wb_done;
    assign w_ack = r_stb && wb_ack_i;

`ifdef DEBUG_BRIDGE_WB_TIMEOUT_EN
    localparam int WT_W = $clog2(WB_TIMEOUT + 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(WB_TIMEOUT - 1);
    logic [WT_W-1:0] r_wb_tmr;

    assign w_wb_tmo = r_stb && !wb_ack_i && (r_wb_tmr == WT_LAST);

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn)                   r_wb_tmr <= '0;
        else if (r_stb && !w_wb_done)     r_wb_tmr <= r_wb_tmr + WT_W'(1);
        else                              r_wb_tmr <= '0;
    end
`else
    assign w_wb_tmo = 1'b0;
`endif

    assign w_wb_done = w_ack || w_wb_tmo;

    // ------------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------------
    state_t          r_state;
    logic            r_cmd_rd;
    logic [7:0]      r_len;
    logic [29:0]     r_addr;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_shift;
    logic [31:0]     r_rdata;
    logic [2:0]      r_tx_idx;
    logic [BT_W-1:0] r_byte_tmr;
    logic            r_err, r_oeb, r_cyc, r_we;
    logic [31:0]     r_adr, r_dat;

    logic [31:0] w_word;
    logic [29:0] w_addr_nxt;
    assign w_word     = {r_shift, r_rx_shift};
    assign w_addr_nxt = r_addr + 30'd1;

    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            r_state    <= S_IDLE;
            r_cmd_rd   <= 1'b0;
            r_len      <= '0;
            r_addr     <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
            r_rdata    <= '0;
            r_tx_idx   <= '0;
            r_byte_tmr <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_err      <= 1'b0;
            r_oeb      <= 1'b1;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_dat      <= '0;
        end else begin
            // NOTE: every state and output register here uses <=, so all
            // decisions in this block see the values from before this edge.
            r_tx_start <= 1'b0;
            r_oeb      <= ~enable;
            if (r_rx_ferr && enable) r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    r_byte_tmr <= '0;
                    r_byte_cnt <= '0;
                    if (r_rx_valid && enable &&
                        (r_rx_shift == CMD_WR || r_rx_shift == CMD_RD)) begin
                        r_cmd_rd <= (r_rx_shift == CMD_RD);
                        r_state  <= S_LEN;
                    end
                end

                S_LEN, S_ADDR, S_WDATA: begin
                    if (!enable || r_rx_ferr) begin
                        r_state <= S_IDLE;
                    end else if (r_rx_valid) begin
                        r_byte_tmr <= '0;
                        r_shift    <= w_word[23:0];
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        case (r_state)
                            S_LEN: begin
                                r_len      <= r_rx_shift;
                                r_byte_cnt <= '0;
                                r_state    <= S_ADDR;
                            end
                            S_ADDR: begin
                                if (r_byte_cnt == 2'd3) begin
                                    r_addr <= w_word[29:0];
                                    if (r_len == 8'd0) begin
                                        r_state <= S_IDLE;
                                    end else if (r_cmd_rd) begin
                                        r_adr   <= {w_word[29:0], 2'b00};
                                        r_cyc   <= 1'b1;
                                        r_stb   <= 1'b1;
                                        r_we    <= 1'b0;
                                        r_state <= S_WB_RD;
                                    end else begin
                                        r_state <= S_WDATA;
                                    end
                                end
                            end
                            default: begin  // S_WDATA
                                if (r_byte_cnt == 2'd3) begin
                                    r_adr   <= {r_addr, 2'b00};
                                    r_dat   <= w_word;
                                    r_cyc   <= 1'b1;
                                    r_stb   <= 1'b1;
                                    r_we    <= 1'b1;
                                    r_state <= S_WB_WR;
                                end
                            end
                        endcase
                    end else if (r_byte_tmr == BT_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_byte_tmr <= r_byte_tmr + BT_W'(1);
                    end
                end

                S_WB_WR: begin
                    if (w_wb_done) begin
                        r_cyc      <= 1'b0;
                        r_stb      <= 1'b0;
                        r_we       <= 1'b0;
                        r_addr     <= w_addr_nxt;
                        r_len      <= r_len - 8'd1;
                        r_byte_tmr <= '0;
                        r_byte_cnt <= '0;
                        if (!w_ack) r_err <= 1'b1;
                        r_state <= (r_len == 8'd1 || !enable) ? S_IDLE : S_WDATA;
                    end
                end

                S_WB_RD: begin
                    if (w_wb_done) begin
                        r_cyc    <= 1'b0;
                        r_stb    <= 1'b0;
                        r_rdata  <= w_ack ? wb_dat_i : 32'hFFFF_FFFF;
                        r_tx_idx <= '0;
                        if (!w_ack) r_err <= 1'b1;
                        r_state <= enable ? S_TX : S_IDLE;
                    end
                end

                S_TX: begin
                    // Decisions only between bytes, so a disable never truncates a byte.
                    if (w_tx_ready) begin
                        if (!enable) begin
                            r_state <= S_IDLE;
                        end else if (r_tx_idx == 3'd4) begin
                            r_addr <= w_addr_nxt;
                            r_len  <= r_len - 8'd1;
                            if (r_len == 8'd1) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_adr   <= {w_addr_nxt, 2'b00};
                                r_cyc   <= 1'b1;
                                r_stb   <= 1'b1;
                                r_we    <= 1'b0;
                                r_state <= S_WB_RD;
                            end
                        end else begin
                            r_tx_start <= 1'b1;
                            r_tx_data  <= r_rdata[31:24];
                            r_rdata    <= {r_rdata[23:0], 8'h00};
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign debug_out = r_tx_out;
    assign debug_oeb = r_oeb;
    assign wb_adr_o  = r_adr;
    assign wb_dat_o  = r_dat;
    assign wb_sel_o  = 4'hF;
    assign wb_we_o   = r_we;
    assign wb_cyc_o  = r_cyc;
    assign wb_stb_o  = r_stb;
    assign busy      = (r_state != S_IDLE);
    assign err       = r_err;

endmodule

// File: doc/debug_uart_wb_bridge.md
Name: debug_uart_wb_bridge

Overview:
- Management-side responder for the host-driven debug UART link: receives framed command bytes on the debug serial input and executes Wishbone master writes/reads on the management bus.
- Returns read data serially on the debug output.
- Sits between the debug_in/debug_out pads and the SoC Wishbone interconnect; it is the device-side counterpart of the bench debug UART host.
- Frame: cmd byte (0x01 write, 0x02 read), length byte N (words), 4-byte word address (MSB first), then N 32-bit words MSB first (write only).

Parameters:
- CLKS_PER_BIT, 347, core_clk cycles per UART bit (40 MHz / 115200).
- BYTE_TIMEOUT, 65535, cycles allowed between bytes inside a frame before abort.
- WB_TIMEOUT, 255, cycles to wait for wb_ack_i (used only with the optional feature).

Ports:
- core_clk  in  1  system clock
- core_rstn  in  1  asynchronous active-low reset
- debug_in  in  1  UART RX from pad, asynchronous
- debug_out  out  1  UART TX to pad, idle high
- debug_oeb  out  1  pad output enable, active low; 0 while the bridge is enabled
- enable  in  1  bridge enable; 0 holds the FSM in IDLE
- wb_adr_o  out  32  byte address = {word_addr[29:0], 2'b00}
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  always 4'hF
- wb_we_o  out  1  write strobe qualifier
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- busy  out  1  high whenever the FSM is not IDLE
- err  out  1  sticky error flag; cleared only by reset

Behaviour:
- Reset (async, core_rstn=0): debug_out=1, debug_oeb=1, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=wb_dat_o=0, busy=0, err=0, FSM=IDLE.
- After reset, debug_oeb follows ~enable.
- RX path:
  - debug_in passes through a 2-flop synchronizer.
  - Start is detected on a falling edge and re-checked at the half-bit point; if high at half-bit, treat as a glitch and ignore.
  - Data bits are sampled at bit centres, LSB first.
  - Stop bit is sampled at centre. Stop=0 is a framing error: discard the byte, set err, and return the FSM to IDLE.
- TX path:
  - 8N1, LSB first, CLKS_PER_BIT per bit.
  - A byte is loaded only when the transmitter is idle.
  - debug_out=1 between bytes.
- FSM states: IDLE, LEN, ADDR (4 bytes), WDATA (4 bytes), WB_WR, WB_RD, TX (4 bytes), then next word or IDLE.
  - IDLE: byte 0x01/0x02 latches cmd and goes to LEN. Any other byte is dropped silently (no err).
  - LEN: latch N (8 bits). Then go to ADDR.
  - ADDR: shift in 4 bytes MSB first. Then:
    - N=0: return to IDLE with no bus access and no TX.
    - write: go to WDATA.
    - read: go to WB_RD.
  - WDATA: shift in 4 bytes, then go to WB_WR.
  - WB_WR: assert cyc/stb/we with adr and dat held stable. On the wb_ack_i cycle, deassert all three in the next cycle, increment word_addr by 1 (30-bit wrap, 0x3FFFFFFF -> 0), and decrement N. If N>0, go to WDATA, else IDLE.
  - WB_RD: assert cyc/stb with we=0. Latch wb_dat_i on ack and deassert next cycle, then go to TX.
  - TX: send 4 bytes MSB first. Increment address, decrement N; if N>0 go to WB_RD, else IDLE.
- Bus handshake: one transfer at a time. wb_ack_i seen while stb=0 is ignored.
- Byte timeout: in LEN/ADDR/WDATA, if no byte completes within BYTE_TIMEOUT cycles, go to IDLE, set err, perform no bus access for the partial word.
- enable deasserted mid-frame:
  - Abort to IDLE at the next byte boundary or after the current Wishbone ack.
  - An in-flight bus cycle is never dropped before ack.
- Bytes arriving during WB_RD/TX are discarded; the host must wait for the reply.

Optional Feature:
- Macro: DEBUG_BRIDGE_WB_TIMEOUT_EN.
- Defined: a counter runs during WB_WR/WB_RD. If wb_ack_i is absent for WB_TIMEOUT cycles:
  - deassert cyc/stb and set err;
  - a read returns 32'hFFFFFFFF over TX;
  - the frame then continues normally (address increments).
- Undefined: the bridge waits for ack indefinitely, and WB_TIMEOUT is unused.

Test Plan:
- Write 1 word: UART 01 01 00 00 00 04 DE AD BE EF -> one Wishbone write with adr=0x00000010, dat=0xDEADBEEF, sel=F, we=1; cyc/stb deassert the cycle after ack; err=0; debug_out stays 1.
- Burst read: UART 02 02 00 00 00 10; slave returns 0x12345678 then 0xCAFEF00D -> reads at 0x40 and 0x44; TX bytes 12 34 56 78 CA FE F0 0D with correct bit timing.
- Length 0 plus junk: send 55, then 01 00 00 00 00 00 -> no bus cycle; err=0; the next valid frame executes.
- Framing error: byte with stop bit 0 during ADDR -> err=1, FSM returns to IDLE, no bus cycle; a following valid frame still works.
- Byte timeout and reset: send 01 01 00 then idle >BYTE_TIMEOUT cycles -> err=1, busy=0. Pulse core_rstn low mid-read frame -> all outputs at reset values immediately.
- With DEBUG_BRIDGE_WB_TIMEOUT_EN: read with ack never asserted -> after 255 cycles cyc falls, err=1, TX returns FF FF FF FF.
